dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares one single-port byte-wide data RAM between fetch (10-byte instruction reads) and memory stage (8-byte quad read/write).
//  Sequences each multi-byte access one byte per cycle, little-endian, and returns per-requester done/stall/error to pipeline control.
//  Memory stage has fixed priority over fetch, as it holds the older instruction. Out-of-range accesses map to STAT_ADR upstream.
// PARAMETERS
//  ADDR_W     10    RAM byte-address width.
//  MEM_DEPTH  1024  RAM size in bytes; valid addresses 0..MEM_DEPTH-1.
//  F_BYTES    10    bytes per fetch read (max Y86 instruction length).
//  M_BYTES    8     bytes per memory-stage access.
// PORTS
//  clk_i        in   1       clock, rising edge.
//  rst_n_i      in   1       reset; synchronous and active-low.
//  f_req_i      in   1       fetch read request; held until f_done_o or cancel.
//  f_cancel_i   in   1       abort in-flight fetch (mispredict / ret redirect).
//  f_addr_i     in   64      fetch byte address (PC).
//  f_rdata_o    out  80      fetched bytes, byte0 in [7:0].
//  f_done_o     out  1       one-cycle completion pulse.
//  f_err_o      out  1       address error; valid with f_done_o.
//  f_stall_o    out  1       f_req_i & ~f_done_o (combinational).
//  m_req_i      in   1       memory-stage request; held until m_done_o.
//  m_we_i       in   1       1 = write quad, 0 = read quad.
//  m_addr_i     in   64      memory byte address (valE or valA).
//  m_wdata_i    in   64      write data; byte0 = [7:0].
//  m_rdata_o    out  64      read data (valM).
//  m_done_o     out  1       one-cycle completion pulse.
//  m_err_o      out  1       address error; valid with m_done_o.
//  m_stall_o    out  1       m_req_i & ~m_done_o (combinational).
//  ram_en_o     out  1       RAM access strobe.
//  ram_we_o     out  1       RAM write enable.
//  ram_addr_o   out  ADDR_W  RAM byte address.
//  ram_wdata_o  out  8       RAM write byte.
//  ram_rdata_i  in   8       RAM read byte, valid the cycle after ram_en_o read.
// BEHAVIOUR
//  - States: IDLE, XFER, TAIL, DONE. Owner register is FETCH or MEM.
//  - IDLE: requests are sampled. m_req_i wins over f_req_i.
//    On acceptance: latch addr, we, and wdata; set N = M_BYTES or F_BYTES; cnt = 0.
//  - Range check in IDLE: addr + N - 1 >= MEM_DEPTH, computed 65-bit so it cannot wrap.
//    Fail -> DONE directly with err = 1, rdata = 0, and no ram_en_o.
//  - XFER (N cycles): ram_en_o = 1, ram_addr_o = base + cnt, ram_we_o = owner write.
//    ram_wdata_o = wdata[8*cnt +: 8]. If cnt > 0, capture ram_rdata_i into byte cnt-1. cnt++.
//    At cnt == N-1 -> TAIL.
//  - TAIL: ram_en_o = 0. Capture byte N-1 (reads). -> DONE.
//  - DONE: owner's done_o = 1 for exactly this cycle. -> IDLE. No request is accepted in DONE.
//  - Latency: request sampled in IDLE at cycle 0 gives done at cycle N+2.
//    Mem: cycle 10. Fetch: cycle 12. Range error: cycle 1.
//  - rdata_o holds its last completed value until the owner's next read completes.
//    Writes leave m_rdata_o unchanged.
//  - f_cancel_i sampled high while owner = FETCH in XFER/TAIL/DONE:
//    next state IDLE, ram_en_o = 0 next cycle, no f_done_o, f_rdata_o unchanged.
//    Ignored when owner = MEM; memory writes are never aborted mid-quad.
//  - f_cancel_i with f_req_i in IDLE: request not accepted.
//  - Requests must stay stable while pending. Changes after acceptance are ignored (latched copy used).
//  - Reset (synchronous): state IDLE, owner FETCH, cnt 0.
//    All *_done_o, *_err_o, and ram_* outputs = 0. f_rdata_o and m_rdata_o = 0.
//    Mid-operation reset abandons the transfer; RAM bytes already written remain.
// TESTING
//  1. m_req=1, we=1, addr 0x10, wdata 0x1122334455667788
//     -> RAM[0x10..0x17] = 88,77,...,11; m_done_o only at cycle 10, m_err_o = 0.
//  2. RAM[0..9] = 30 F4 01..08; f_req, addr 0
//     -> f_rdata_o = 0x0807060504030201F430, f_done_o at cycle 12.
//  3. f_req and m_req (read 0x10) both at cycle 0
//     -> m_done cycle 10, fetch accepted cycle 11, f_done cycle 23, f_stall_o high cycles 0-22.
//  4. m_req read addr 0x3FC (1020) -> ram_en_o never 1; m_done_o and m_err_o = 1 at cycle 1.
//     Addr 0xFFFFFFFFFFFFFFFC -> same (no wrap).
//  5. Fetch at 0x20, f_cancel_i at cycle 4, m_req pending -> ram_en_o from fetch stops at cycle 5.
//     No f_done_o. Mem accepted cycle 5.
//  6. rst_n_i low at cycle 3 of write to 0x40 -> IDLE and all outputs 0 next cycle.
//     RAM[0x40..0x41] written, RAM[0x42..0x47] untouched.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a byte-wide single-port RAM between fetch and memory stage, one byte per cycle
module dmem_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int F_BYTES   = 10,
  parameter int M_BYTES   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   f_req_i,
  input  logic                   f_cancel_i,
  input  logic [63:0]            f_addr_i,
  output logic [8*F_BYTES-1:0]   f_rdata_o,
  output logic                   f_done_o,
  output logic                   f_err_o,
  output logic                   f_stall_o,
  input  logic                   m_req_i,
  input  logic                   m_we_i,
  input  logic [63:0]            m_addr_i,
  input  logic [8*M_BYTES-1:0]   m_wdata_i,
  output logic [8*M_BYTES-1:0]   m_rdata_o,
  output logic                   m_done_o,
  output logic                   m_err_o,
  output logic                   m_stall_o,
  output logic                   ram_en_o,
  output logic                   ram_we_o,
  output logic [ADDR_W-1:0]      ram_addr_o,
  output logic [7:0]             ram_wdata_o,
  input  logic [7:0]             ram_rdata_i
);
  localparam int CW = $clog2((F_BYTES > M_BYTES ? F_BYTES : M_BYTES) + 1);
  typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;
  state_t                 state_q, state_d;
  logic                   own_m_q, own_m_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [8*M_BYTES-1:0]   wdata_q, wdata_d, m_rdata_q, m_rdata_d;
  logic [CW-1:0]          cnt_q, cnt_d, n_last, idx;
  logic [8*F_BYTES-1:0]   buf_q, buf_d, f_rdata_q, f_rdata_d;
  logic [63:0]            sel_addr;
  logic [64:0]            last_addr;
  logic                   start, range_err, f_kill, cap;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      own_m_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      f_rdata_q <= '0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_m_q   <= own_m_d;
      we_q      <= we_d;
      err_q     <= err_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      f_rdata_q <= f_rdata_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  always_comb begin
    sel_addr  = m_req_i ? m_addr_i : f_addr_i;
    last_addr = {1'b0, sel_addr} + (m_req_i ? 65'(M_BYTES - 1) : 65'(F_BYTES - 1));
    range_err = last_addr >= 65'(MEM_DEPTH);
    start     = state_q == IDLE && (m_req_i || (f_req_i && !f_cancel_i));
    f_kill    = f_cancel_i && !own_m_q && state_q != IDLE;
    n_last    = own_m_q ? CW'(M_BYTES - 1) : CW'(F_BYTES - 1);
    state_d   = state_q == IDLE ? (start ? (range_err ? DONE : XFER) : IDLE)
              : f_kill ? IDLE
              : state_q == XFER ? (cnt_q == n_last ? TAIL : XFER)
              : state_q == TAIL ? DONE : IDLE;
    own_m_d   = start ? m_req_i : own_m_q;
    we_d      = start ? m_req_i && m_we_i : we_q;
    err_d     = start ? range_err : err_q;
    base_d    = start ? sel_addr[ADDR_W-1:0] : base_q;
    wdata_d   = start ? m_wdata_i : wdata_q;
    cnt_d     = state_q == XFER ? cnt_q + 1'b1 : '0;
    cap       = !we_q && ((state_q == XFER && cnt_q != '0) || state_q == TAIL);
    idx       = state_q == TAIL ? n_last : cnt_q - 1'b1;
    buf_d     = start ? '0 : buf_q;
    if (cap) buf_d[{idx, 3'b000} +: 8] = ram_rdata_i;
  end

  always_comb begin
    ram_en_o    = state_q == XFER;
    ram_we_o    = ram_en_o && we_q;
    ram_addr_o  = ram_en_o ? base_q + ADDR_W'(cnt_q) : '0;
    ram_wdata_o = ram_we_o ? wdata_q[{cnt_q, 3'b000} +: 8] : '0;
    f_done_o    = state_q == DONE && !own_m_q && !f_cancel_i;
    m_done_o    = state_q == DONE && own_m_q;
    f_err_o     = f_done_o && err_q;
    m_err_o     = m_done_o && err_q;
    f_stall_o   = f_req_i && !f_done_o;
    m_stall_o   = m_req_i && !m_done_o;
    f_rdata_d   = f_done_o ? buf_q : f_rdata_q;
    m_rdata_d   = m_done_o && !we_q ? buf_q[8*M_BYTES-1:0] : m_rdata_q;
    f_rdata_o   = f_rdata_d;
    m_rdata_o   = m_rdata_d;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a byte RAM model for dmem_port_arbiter
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_cancel, f_done, f_err, f_stall;
  logic [63:0] f_addr;
  logic [79:0] f_rdata;
  logic        m_req, m_we, m_done, m_err, m_stall;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  logic        ld;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;
  int          cyc = 0;
  int          en_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [79:0] data;
  } exp_t;
  exp_t fq[$];
  exp_t mq[$];

  dmem_port_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .f_req_i(f_req), .f_cancel_i(f_cancel), .f_addr_i(f_addr), .f_rdata_o(f_rdata),
    .f_done_o(f_done), .f_err_o(f_err), .f_stall_o(f_stall),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_rdata_o(m_rdata), .m_done_o(m_done), .m_err_o(m_err), .m_stall_o(m_stall),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) mem[ld_addr] <= ld_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) if (ram_en) en_cnt <= en_cnt + 1;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m_done) begin
      if (mq.size() == 0) chk("m_done_unexpected", 80'(m_done), 80'd0);
      else begin
        e = mq.pop_front();
        chk("m_done_cycle", 80'(cyc), 80'(e.cyc));
        chk("m_err", 80'(m_err), 80'(e.err));
        chk("m_rdata", 80'(m_rdata), e.data);
      end
    end
    if (f_done) begin
      if (fq.size() == 0) chk("f_done_unexpected", 80'(f_done), 80'd0);
      else begin
        e = fq.pop_front();
        chk("f_done_cycle", 80'(cyc), 80'(e.cyc));
        chk("f_err", 80'(f_err), 80'(e.err));
        chk("f_rdata", f_rdata, e.data);
      end
    end
  end

  task automatic m_op(input logic we, input logic [63:0] a, input logic [63:0] wd,
                      input int lat, input logic err, input logic [63:0] exp_rd);
    exp_t e;
    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = a; m_wdata = wd;
    e.cyc = cyc + lat; e.err = err; e.data = {16'h0, exp_rd};
    mq.push_back(e);
    for (int i = 0; i < 100 && !m_done; i++) @(negedge clk);
    chk("m_timeout", 80'(m_done), 80'd1);
    m_req = 1'b0; m_we = 1'b0;
  endtask

  task automatic f_op(input logic [63:0] a, input int lat, input logic err, input logic [79:0] exp_rd);
    exp_t e;
    @(negedge clk);
    f_req = 1'b1; f_addr = a;
    e.cyc = cyc + lat; e.err = err; e.data = exp_rd;
    fq.push_back(e);
    for (int i = 0; i < 100 && !f_done; i++) @(negedge clk);
    chk("f_timeout", 80'(f_done), 80'd1);
    f_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] w1, w6;
    logic [7:0]  pre [0:9];
    int          c, en0;
    exp_t        e;
    w1 = 64'h1122334455667788;
    w6 = 64'hCAFEBABEDEADBEEF;
    pre = '{8'h30, 8'hF4, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    rst_n = 1'b0; f_req = 0; f_cancel = 0; f_addr = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    ld = 0; ld_addr = 0; ld_data = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      ld = 1'b1;
      ld_addr = i < 10 ? 10'(i) : 10'(1016 + i - 10);
      ld_data = i < 10 ? pre[i] : 8'(8'hA0 + i - 10);
    end
    @(negedge clk);
    ld = 1'b0;
    chk("rst_ram_en", 80'(ram_en), 80'd0);
    chk("rst_ram_we", 80'(ram_we), 80'd0);
    chk("rst_ram_addr", 80'(ram_addr), 80'd0);
    chk("rst_done_err", 80'({f_done, f_err, m_done, m_err}), 80'd0);
    chk("rst_f_rdata", f_rdata, 80'd0);
    chk("rst_m_rdata", 80'(m_rdata), 80'd0);
    rst_n = 1'b1;
    // quad write, byte 0 lands at the lowest address
    m_op(1'b1, 64'h10, w1, 10, 1'b0, 64'h0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk("t1_ram", 80'(mem[16+i]), 80'(w1[8*i +: 8]));
    f_op(64'h0, 12, 1'b0, 80'h0807060504030201F430);
    fork
      m_op(1'b0, 64'h10, 64'h0, 10, 1'b0, w1);
      f_op(64'h0, 23, 1'b0, 80'h0807060504030201F430);
      begin
        @(negedge clk);
        for (int k = 1; k <= 23; k++) begin
          @(negedge clk);
          chk("t3_f_stall", 80'(f_stall), 80'(k < 23));
        end
      end
    join
    en0 = en_cnt;
    m_op(1'b0, 64'h3F8, 64'h0, 10, 1'b0, 64'hA7A6A5A4A3A2A1A0);
    chk("t4_top_quad_en", 80'(en_cnt - en0), 80'd8);
    en0 = en_cnt;
    m_op(1'b0, 64'h3FC, 64'h0, 1, 1'b1, 64'h0);
    m_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 1'b1, 64'h0);
    @(negedge clk);
    chk("t4_no_en", 80'(en_cnt - en0), 80'd0);
    f_req = 1'b1; f_cancel = 1'b1; f_addr = 64'h0;
    repeat (3) @(negedge clk);
    chk("idle_cancel_en", 80'(ram_en), 80'd0);
    chk("idle_cancel_stall", 80'(f_stall), 80'd1);
    f_req = 1'b0; f_cancel = 1'b0;
    @(negedge clk);
    c = cyc;
    f_req = 1'b1; f_addr = 64'h20;
    repeat (2) @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h0;
    e.cyc = c + 15; e.err = 1'b0; e.data = 80'h060504030201F430;
    mq.push_back(e);
    repeat (2) @(negedge clk);
    chk("t5_en_before_cancel", 80'(ram_en), 80'd1);
    f_cancel = 1'b1;
    @(negedge clk);
    chk("t5_en_stopped", 80'(ram_en), 80'd0);
    chk("t5_m_stall", 80'(m_stall), 80'd1);
    chk("t5_f_rdata_held", f_rdata, 80'h0807060504030201F430);
    f_cancel = 1'b0; f_req = 1'b0;
    for (int i = 0; i < 100 && !m_done; i++) @(negedge clk);
    chk("t5_m_timeout", 80'(m_done), 80'd1);
    m_req = 1'b0;
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b1; m_addr = 64'h40; m_wdata = w6;
    @(negedge clk);
    chk("t6_addr0", 80'(ram_addr), 80'h40);
    @(negedge clk);
    chk("t6_addr1", 80'({ram_en, ram_addr}), 80'({1'b1, 10'h41}));
    rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0;
    @(negedge clk);
    chk("t6_ram_off", 80'({ram_en, ram_we, ram_addr, ram_wdata}), 80'd0);
    chk("t6_done_err", 80'({f_done, f_err, m_done, m_err}), 80'd0);
    chk("t6_f_rdata", f_rdata, 80'd0);
    chk("t6_m_rdata", 80'(m_rdata), 80'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ram40", 80'(mem[10'h40]), 80'hEF);
    chk("t6_ram41", 80'(mem[10'h41]), 80'hBE);
    for (int i = 2; i < 8; i++) chk("t6_untouched", 80'(mem[10'h40 + i]), 80'h00);
    f_op(64'h0, 12, 1'b0, 80'h0807060504030201F430);
    repeat (2) @(negedge clk);
    chk("mq_drained", 80'(mq.size()), 80'd0);
    chk("fq_drained", 80'(fq.size()), 80'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
